// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: absorbs 2-slot icache beats, compacts valid slots into a
// circular buffer, and issues up to two entries per cycle to the decoder.
module inst_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       icache_valid_i,
  output logic                       icache_ready_o,
  input  logic [31:0]                icache_pc_i,
  input  logic [63:0]                icache_inst_i,
  input  logic [1:0]                 icache_mask_i,
  input  logic                       icache_excp_i,
  output logic [1:0]                 dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [63:0]                dec_pc_o,
  output logic [63:0]                dec_inst_o,
  output logic [1:0]                 dec_excp_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] inst_mem_q [DEPTH];
  logic        excp_mem_q [DEPTH];

  ptr_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;

  ptr_t head1, tail1;
  logic [FETCH_WIDTH-1:0] valid_w;
  logic push;
  cnt_t n_push, n_pop;

  logic        wr0_en, wr1_en;
  logic [31:0] wr0_pc, wr0_inst, wr1_pc, wr1_inst;

  assign head1 = head_q + ptr_t'(1);
  assign tail1 = tail_q + ptr_t'(1);

  // Readiness looks only at registered occupancy so the icache path never sees dec_ready_i.
  assign icache_ready_o = (count_q <= cnt_t'(DEPTH - 2));

  assign valid_w[0] = (count_q >= cnt_t'(1));
  assign valid_w[1] = (count_q >= cnt_t'(2)) && !excp_mem_q[head_q];
  assign dec_valid_o = valid_w;

  assign dec_pc_o   = {pc_mem_q[head1],   pc_mem_q[head_q]};
  assign dec_inst_o = {inst_mem_q[head1], inst_mem_q[head_q]};
  assign dec_excp_o = {excp_mem_q[head1], excp_mem_q[head_q]};
  assign count_o    = count_q;

  always_comb begin
    push   = icache_valid_i && icache_ready_o && !flush_i;
    n_push = push ? (cnt_t'(icache_mask_i[0]) + cnt_t'(icache_mask_i[1])) : '0;
    n_pop  = (dec_ready_i && !flush_i) ? (cnt_t'(valid_w[0]) + cnt_t'(valid_w[1])) : '0;

    // A lone slot 1 is compacted down to the tail entry with its own PC.
    wr0_en   = push && (icache_mask_i != 2'b00);
    wr0_pc   = icache_mask_i[0] ? icache_pc_i : icache_pc_i + 32'd4;
    wr0_inst = icache_mask_i[0] ? icache_inst_i[31:0] : icache_inst_i[63:32];
    wr1_en   = push && (icache_mask_i == 2'b11);
    wr1_pc   = icache_pc_i + 32'd4;
    wr1_inst = icache_inst_i[63:32];

    head_d  = head_q + ptr_t'(n_pop);
    tail_d  = tail_q + ptr_t'(n_push);
    count_d = count_q + n_push - n_pop;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) begin
      pc_mem_q[tail_q]   <= wr0_pc;
      inst_mem_q[tail_q] <= wr0_inst;
      excp_mem_q[tail_q] <= icache_excp_i;
    end
    if (wr1_en) begin
      pc_mem_q[tail1]   <= wr1_pc;
      inst_mem_q[tail1] <= wr1_inst;
      excp_mem_q[tail1] <= icache_excp_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic
// compared against a queue-of-entries reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        icache_valid_i;
  logic        icache_ready_o;
  logic [31:0] icache_pc_i;
  logic [63:0] icache_inst_i;
  logic [1:0]  icache_mask_i;
  logic        icache_excp_i;
  logic [1:0]  dec_valid_o;
  logic        dec_ready_i;
  logic [63:0] dec_pc_o;
  logic [63:0] dec_inst_o;
  logic [1:0]  dec_excp_o;
  logic [3:0]  count_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t mq[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .icache_valid_i (icache_valid_i),
    .icache_ready_o (icache_ready_o),
    .icache_pc_i    (icache_pc_i),
    .icache_inst_i  (icache_inst_i),
    .icache_mask_i  (icache_mask_i),
    .icache_excp_i  (icache_excp_i),
    .dec_valid_o    (dec_valid_o),
    .dec_ready_i    (dec_ready_i),
    .dec_pc_o       (dec_pc_o),
    .dec_inst_o     (dec_inst_o),
    .dec_excp_o     (dec_excp_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] inst,
                       input logic [1:0] m, input logic e, input logic r, input logic f);
    icache_valid_i = v;
    icache_pc_i    = pc;
    icache_inst_i  = inst;
    icache_mask_i  = m;
    icache_excp_i  = e;
    dec_ready_i    = r;
    flush_i        = f;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference: decoder takes one entry, or two unless the first carries an exception.
  function automatic void model_step();
    int n;
    ent_t e;
    bit rdy;
    if (flush_i) begin
      mq.delete();
      return;
    end
    rdy = (DEPTH - mq.size()) >= 2;
    if (dec_ready_i) begin
      n = (mq.size() == 0) ? 0 : ((mq.size() >= 2 && !mq[0].excp) ? 2 : 1);
      for (int i = 0; i < n; i++) void'(mq.pop_front());
    end
    if (icache_valid_i && rdy) begin
      if (icache_mask_i[0]) begin
        e.pc = icache_pc_i; e.inst = icache_inst_i[31:0]; e.excp = icache_excp_i;
        mq.push_back(e);
      end
      if (icache_mask_i[1]) begin
        e.pc = icache_pc_i + 32'd4; e.inst = icache_inst_i[63:32]; e.excp = icache_excp_i;
        mq.push_back(e);
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
      drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    tests++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || icache_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold: count=%0d valid=%b ready=%b, want 0 00 1", count_o, dec_valid_o, icache_ready_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tests++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || icache_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: count=%0d valid=%b ready=%b, want 0 00 1", count_o, dec_valid_o, icache_ready_o);
    end
  endtask

  task automatic test_dual_push();
    drive(1'b1, 32'h1c000000, 64'h02800421_02800400, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tests++;
    if (dec_valid_o !== 2'b11 || dec_pc_o !== 64'h1c000004_1c000000 || count_o !== 4'd2 ||
        dec_inst_o !== 64'h02800421_02800400) begin
      fails++;
      $display("FAIL dual_push: valid=%b pc=%h inst=%h count=%0d, want 11 1c0000041c000000 0280042102800400 2",
               dec_valid_o, dec_pc_o, dec_inst_o, count_o);
    end
    drain();
  endtask

  task automatic test_mask10();
    logic [63:0] inst;
    inst = {$urandom, $urandom};
    drive(1'b1, 32'h1c000010, inst, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tests++;
    if (dec_valid_o !== 2'b01 || count_o !== 4'd1 || dec_pc_o[31:0] !== 32'h1c000014 ||
        dec_inst_o[31:0] !== inst[63:32]) begin
      fails++;
      $display("FAIL mask10: valid=%b count=%0d pc=%h inst=%h, want 01 1 1c000014 %h",
               dec_valid_o, count_o, dec_pc_o[31:0], dec_inst_o[31:0], inst[63:32]);
    end
    drain();
  endtask

  task automatic test_fill();
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 32'h1c000100 + 32'(b * 8), {$urandom, $urandom}, 2'b11, 1'b0, 1'b0, 1'b0);
      tick();
    end
    tests++;
    if (count_o !== 4'd8 || icache_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: count=%0d ready=%b, want 8 0", count_o, icache_ready_o);
    end
    drive(1'b1, 32'h1c000200, 64'h1, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (count_o !== 4'd8) begin
      fails++;
      $display("FAIL full_reject: count=%0d, want 8", count_o);
    end
    drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tests++;
    if (count_o !== 4'd6 || icache_ready_o !== 1'b1 || dec_pc_o[31:0] !== 32'h1c000108) begin
      fails++;
      $display("FAIL fill_pop: count=%0d ready=%b head_pc=%h, want 6 1 1c000108", count_o, icache_ready_o, dec_pc_o[31:0]);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    drive(1'b1, 32'h1c000300, {$urandom, $urandom}, 2'b11, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tests++;
    if (count_o !== 4'd6 || dec_pc_o !== {mq[1].pc, mq[0].pc}) begin
      fails++;
      $display("FAIL push_pop: count=%0d pc=%h, want 6 %h%h", count_o, dec_pc_o, mq[1].pc, mq[0].pc);
    end
  endtask

  task automatic test_random_traffic(input int cycles, input bit with_flush);
    logic [1:0] ev;
    for (int c = 0; c < cycles; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom}, 2'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            with_flush && ($urandom_range(0, 19) == 0));
      tick();
      ev[0] = mq.size() >= 1;
      ev[1] = mq.size() >= 2 && !mq[0].excp;
      tests++;
      if (count_o !== 4'(mq.size()) || dec_valid_o !== ev ||
          icache_ready_o !== ((DEPTH - mq.size()) >= 2)) begin
        fails++;
        $display("FAIL rand_ctrl[%0d]: count=%0d valid=%b ready=%b, want %0d %b %0d",
                 c, count_o, dec_valid_o, icache_ready_o, mq.size(), ev, (DEPTH - mq.size()) >= 2);
      end
      if (ev[0]) begin
        tests++;
        if (dec_pc_o[31:0] !== mq[0].pc || dec_inst_o[31:0] !== mq[0].inst || dec_excp_o[0] !== mq[0].excp) begin
          fails++;
          $display("FAIL rand_slot0[%0d]: pc=%h inst=%h excp=%b, want %h %h %b",
                   c, dec_pc_o[31:0], dec_inst_o[31:0], dec_excp_o[0], mq[0].pc, mq[0].inst, mq[0].excp);
        end
      end
      if (ev[1]) begin
        tests++;
        if (dec_pc_o[63:32] !== mq[1].pc || dec_inst_o[63:32] !== mq[1].inst || dec_excp_o[1] !== mq[1].excp) begin
          fails++;
          $display("FAIL rand_slot1[%0d]: pc=%h inst=%h excp=%b, want %h %h %b",
                   c, dec_pc_o[63:32], dec_inst_o[63:32], dec_excp_o[1], mq[1].pc, mq[1].inst, mq[1].excp);
        end
      end
    end
    idle();
  endtask

  task automatic test_exception();
    drain();
    drive(1'b1, 32'h1c000400, 64'h0000aaaa_0000bbbb, 2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tests++;
    if (dec_valid_o !== 2'b01 || dec_excp_o[0] !== 1'b1 || count_o !== 4'd2) begin
      fails++;
      $display("FAIL excp_first: valid=%b excp0=%b count=%0d, want 01 1 2", dec_valid_o, dec_excp_o[0], count_o);
    end
    drive(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tests++;
    if (dec_valid_o !== 2'b01 || count_o !== 4'd1 || dec_pc_o[31:0] !== 32'h1c000404 || dec_excp_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL excp_second: valid=%b count=%0d pc=%h excp0=%b, want 01 1 1c000404 1",
               dec_valid_o, count_o, dec_pc_o[31:0], dec_excp_o[0]);
    end
    drain();
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 32'h1c000500, 64'h11, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h1c000508, 64'h22, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h1c000510, 64'h33, 2'b01, 1'b0, 1'b0, 1'b0); tick();
    tests++;
    if (count_o !== 4'd5) begin
      fails++;
      $display("FAIL flush_setup: count=%0d, want 5", count_o);
    end
    drive(1'b1, 32'h1c000600, 64'h44, 2'b11, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    tests++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin
      fails++;
      $display("FAIL flush: count=%0d valid=%b, want 0 00", count_o, dec_valid_o);
    end
    tick();
    tests++;
    if (count_o !== 4'd0) begin
      fails++;
      $display("FAIL flush_beat_dropped: count=%0d, want 0", count_o);
    end
    drive(1'b1, 32'h1c000700, 64'h0000_0055_0000_0066, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tests++;
    if (count_o !== 4'd1 || dec_pc_o[31:0] !== 32'h1c000700 || dec_inst_o[31:0] !== 32'h66) begin
      fails++;
      $display("FAIL flush_restart: count=%0d pc=%h inst=%h, want 1 1c000700 00000066",
               count_o, dec_pc_o[31:0], dec_inst_o[31:0]);
    end
    drain();
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 32'h1c000800, 64'h1, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h1c000808, 64'h2, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    tests++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || icache_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: count=%0d valid=%b ready=%b, want 0 00 1", count_o, dec_valid_o, icache_ready_o);
    end
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    tick();
    tests++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin
      fails++;
      $display("FAIL reset_drop: count=%0d valid=%b, want 0 00", count_o, dec_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_dual_push();
    test_mask10();
    test_fill();
    test_push_pop_same_cycle();
    test_random_traffic(20, 1'b0);
    test_exception();
    test_flush();
    test_reset_midrun();
    test_random_traffic(400, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue capacity in single-instruction entries (power of two, >= 4).
REQ-002 SHALL have parameter FETCH_WIDTH, default 2, meaning instruction slots per fetch beat; this block fixes it at 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  discards all queue contents.
REQ-006 SHALL have port icache_valid_i  input  1  fetch beat from the icache is present.
REQ-007 SHALL have port icache_ready_o  output  1  queue accepts a fetch beat this cycle.
REQ-008 SHALL have port icache_pc_i  input  32  PC of slot 0; slot 1 PC = icache_pc_i + 4.
REQ-009 SHALL have port icache_inst_i  input  64  slot 0 in [31:0], slot 1 in [63:32].
REQ-010 SHALL have port icache_mask_i  input  2  per-slot valid bits.
REQ-011 SHALL have port icache_excp_i  input  1  fetch exception (TLB/ADEF); applies to every valid slot of the beat.
REQ-012 SHALL have port dec_valid_o  output  2  per-slot valid bits to the decoder.
REQ-013 SHALL have port dec_ready_i  input  1  decoder consumes every slot with dec_valid_o set.
REQ-014 SHALL have port dec_pc_o  output  64  slot 0 PC in [31:0], slot 1 PC in [63:32].
REQ-015 SHALL have port dec_inst_o  output  64  slot 0 in [31:0], slot 1 in [63:32].
REQ-016 SHALL have port dec_excp_o  output  2  per-slot exception flag.
REQ-017 SHALL have port count_o  output  $clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-018 SHALL store each entry as {pc[31:0], inst[31:0], excp}, in a circular buffer with head pointer, tail pointer and registered count.
REQ-019 SHALL drive icache_ready_o = (DEPTH - count >= 2); it depends only on registered count and never on dec_ready_i.
REQ-020 SHALL accept a beat when icache_valid_i && icache_ready_o && !flush_i.
REQ-021 SHALL write the accepted valid slots compacted, in slot order, starting at tail: mask 11 -> two entries (slot 0 at tail, slot 1 at tail+1); mask 01 -> slot 0 only; mask 10 -> slot 1 only, at tail, with pc = icache_pc_i + 4; mask 00 -> beat accepted, nothing written.
REQ-022 SHALL set dec_valid_o[0] = (count >= 1), taking data from the head entry.
REQ-023 SHALL set dec_valid_o[1] = (count >= 2) && !excp(head), taking data from head+1; an exception entry always issues alone in slot 0.
REQ-024 SHALL compute dec_pc_o, dec_inst_o and dec_excp_o from registered storage only; payload is don't-care in any slot whose valid bit is 0.
REQ-025 SHALL pop popcount(dec_valid_o) entries when dec_ready_i && !flush_i, advancing head by that amount.
REQ-026 SHALL update count as count + pushed - popped when a push and a pop occur in the same cycle.
REQ-027 SHALL NOT bypass input to output; an entry written in cycle N is visible at dec_* no earlier than cycle N+1.
REQ-028 SHALL wrap head and tail modulo DEPTH; pc + 4 wraps modulo 2^32.
REQ-029 SHALL, on flush_i, set head = tail = count = 0 at the next edge; flush_i overrides any same-cycle push or pop, and neither is performed.
REQ-030 SHALL never overflow: count <= DEPTH is guaranteed by REQ-019, and no pop occurs from an empty queue.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear head, tail and count to 0, giving dec_valid_o = 00, count_o = 0 and icache_ready_o = 1 while in reset and after its release.
REQ-032 SHALL leave storage contents unreset; dec_* payload is don't-care while dec_valid_o = 00.
REQ-033 SHALL, when rst_n is asserted mid-operation, drop all queued and in-flight beats with no partial entry surviving.

Verification
REQ-034 Reset, then push pc=0x1c000000, mask=11, inst={0x02800421,0x02800400}, dec_ready_i=0 -> next cycle dec_valid_o=11, dec_pc_o={0x1c000004,0x1c000000}, count_o=2.
REQ-035 Push mask=10 at pc=0x1c000010 into an empty queue -> one entry with pc=0x1c000014 and inst=icache_inst_i[63:32]; dec_valid_o=01; count_o=1.
REQ-036 DEPTH=8: fill with 4 beats of mask=11 while dec_ready_i=0 -> count_o=8, icache_ready_o=0; one pop with dec_ready_i=1 -> count_o=6, icache_ready_o=1.
REQ-037 count_o=6, same-cycle push (mask=11) and pop of 2 -> count_o stays 6; pointers wrap correctly past index 7 and FIFO order is preserved over 20 random beats against a reference model.
REQ-038 Push mask=11 with icache_excp_i=1 -> dec_valid_o=01, dec_excp_o[0]=1; after one pop the second entry issues alone with dec_valid_o=01.
REQ-039 count_o=5, assert flush_i together with icache_valid_i=1 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=00, and the beat presented during flush is not stored.
